// File: rtl/sprite_rom_arbiter_if.sv
// Requester / frame-RAM bus of the sprite ROM arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use the master modport.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                      flush;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rd_valid;
  logic [ID_W-1:0]           rd_id;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_transparent;

  modport slave (
    input  flush, req, req_addr, rom_data,
    output grant, rom_addr, rd_valid, rd_id, rd_data, rd_transparent
  );

  modport master (
    output flush, req, req_addr, rom_data,
    input  grant, rom_addr, rd_valid, rd_id, rd_data, rd_transparent
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite frame RAM among NUM_REQ requesters.
// Optional SPRITE_ARB_STATS_EN adds a saturating stall_cnt output.
module sprite_rom_arbiter #(
  parameter int                NUM_REQ   = 4,
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 24,
  parameter int                ROM_LAT   = 1,
  parameter logic [DATA_W-1:0] KEY_COLOR = 24'hFF0000
) (
  input  logic Clk,
  input  logic Reset_n,
  sprite_rom_arbiter_if.slave bus
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  // Stage 0 lines up with rom_addr, stage ROM_LAT with the returned rom_data.
  localparam int DEPTH = ROM_LAT + 1;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] grant_next;
  logic               transfer;
  logic [ADDR_W-1:0]  rom_addr_reg;
  logic               tag_valid_reg [DEPTH];
  logic [ID_W-1:0]    tag_id_reg    [DEPTH];
  logic               rd_valid_reg;
  logic [ID_W-1:0]    rd_id_reg;
  logic [DATA_W-1:0]  rd_data_reg;
  logic               rd_transparent_reg;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
  end

  // First active request at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req[wrap_add(ptr_reg, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_reg, k);
      end
    end
  end

  always_comb begin
    grant_next = '0;
    if (Reset_n && !bus.flush && win_found) grant_next[win_idx] = 1'b1;
  end

  assign transfer  = |(bus.req & grant_next);
  assign bus.grant = grant_next;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_reg      <= '0;
      rom_addr_reg <= '0;
    end else if (bus.flush) begin
      ptr_reg <= '0;
    end else if (transfer) begin
      ptr_reg      <= wrap_add(win_idx, 1);
      rom_addr_reg <= addr_arr[win_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag_valid_reg[0] <= 1'b0;
      tag_id_reg[0]    <= '0;
    end else begin
      tag_valid_reg[0] <= transfer && !bus.flush;
      if (transfer) tag_id_reg[0] <= win_idx;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        tag_valid_reg[gi] <= 1'b0;
        tag_id_reg[gi]    <= '0;
      end else begin
        tag_valid_reg[gi] <= tag_valid_reg[gi-1] && !bus.flush;
        tag_id_reg[gi]    <= tag_id_reg[gi-1];
      end
    end
  end

  // Pixel and ID only move on a valid return so the last pixel stays visible.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_reg       <= 1'b0;
      rd_id_reg          <= '0;
      rd_data_reg        <= '0;
      rd_transparent_reg <= 1'b0;
    end else if (bus.flush) begin
      rd_valid_reg       <= 1'b0;
      rd_transparent_reg <= 1'b0;
    end else begin
      rd_valid_reg       <= tag_valid_reg[DEPTH-1];
      rd_transparent_reg <= tag_valid_reg[DEPTH-1] && (bus.rom_data == KEY_COLOR);
      if (tag_valid_reg[DEPTH-1]) begin
        rd_id_reg   <= tag_id_reg[DEPTH-1];
        rd_data_reg <= bus.rom_data;
      end
    end
  end

  assign bus.rom_addr       = rom_addr_reg;
  assign bus.rd_valid       = rd_valid_reg;
  assign bus.rd_id          = rd_id_reg;
  assign bus.rd_data        = rd_data_reg;
  assign bus.rd_transparent = rd_transparent_reg;

`ifdef SPRITE_ARB_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_reg <= '0;
    end else if (bus.flush) begin
      stall_cnt_reg <= '0;
    end else if ((|(bus.req & ~grant_next)) && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed table-driven bench for sprite_rom_arbiter with a ROM_LAT=1 frame-RAM model.
// Hand sequences cover mid-stream reset and the SPRITE_ARB_STATS_EN counter.
module tb_sprite_rom_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 24;
  localparam int NROWS   = 34;

  typedef struct {
    logic                      flush;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addrs;
    logic [NUM_REQ-1:0]        grant;
    logic [ADDR_W-1:0]         rom_addr;
    logic                      rd_valid;
    logic [1:0]                rd_id;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_tr;
  } vec_t;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;
  vec_t tbl [NROWS];
  logic [NUM_REQ*ADDR_W-1:0] a_rr, a_lat, a_key;
`ifdef SPRITE_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1), .KEY_COLOR(24'hFF0000)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] ram_f(input logic [ADDR_W-1:0] a);
    case (a)
      19'h07:  return 24'hFF0000;
      19'h08:  return 24'hFF0001;
      19'h55:  return 24'h00AB12;
      default: return {5'b0, a};
    endcase
  endfunction

  // Single-cycle registered-read frame RAM.
  initial bus.rom_data = '0;
  always @(posedge Clk) bus.rom_data <= ram_f(bus.rom_addr);

  function automatic logic [NUM_REQ*ADDR_W-1:0] pk(input logic [ADDR_W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic fl, input logic [3:0] rq, input logic [NUM_REQ*ADDR_W-1:0] ad,
                              input logic [3:0] g, input logic [ADDR_W-1:0] ra, input logic v,
                              input logic [1:0] id, input logic [DATA_W-1:0] d, input logic tr);
    vec_t r;
    r.flush = fl; r.req = rq; r.addrs = ad; r.grant = g; r.rom_addr = ra;
    r.rd_valid = v; r.rd_id = id; r.rd_data = d; r.rd_tr = tr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_rr  = pk(19'h10, 19'h20, 19'h30, 19'h40);
    a_lat = pk(19'h10, 19'h20, 19'h55, 19'h40);
    a_key = pk(19'h07, 19'h08, 19'h30, 19'h40);

    // round-robin with all requesting
    tbl[0]  = mk(0, 4'b1111, a_rr, 4'b0001, 19'h10, 0, 0, 24'h0, 0);
    tbl[1]  = mk(0, 4'b1111, a_rr, 4'b0010, 19'h20, 0, 0, 24'h0, 0);
    tbl[2]  = mk(0, 4'b1111, a_rr, 4'b0100, 19'h30, 1, 0, 24'h10, 0);
    tbl[3]  = mk(0, 4'b1111, a_rr, 4'b1000, 19'h40, 1, 1, 24'h20, 0);
    tbl[4]  = mk(0, 4'b1111, a_rr, 4'b0001, 19'h10, 1, 2, 24'h30, 0);
    tbl[5]  = mk(0, 4'b1111, a_rr, 4'b0010, 19'h20, 1, 3, 24'h40, 0);
    tbl[6]  = mk(0, 4'b1111, a_rr, 4'b0100, 19'h30, 1, 0, 24'h10, 0);
    tbl[7]  = mk(0, 4'b1111, a_rr, 4'b1000, 19'h40, 1, 1, 24'h20, 0);
    tbl[8]  = mk(0, 4'b0000, a_rr, 4'b0000, 19'h40, 1, 2, 24'h30, 0);
    tbl[9]  = mk(0, 4'b0000, a_rr, 4'b0000, 19'h40, 1, 3, 24'h40, 0);
    tbl[10] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h40, 0, 3, 24'h40, 0);
    // single pulse from requester 2, latency
    tbl[11] = mk(0, 4'b0100, a_lat, 4'b0100, 19'h55, 0, 3, 24'h40, 0);
    tbl[12] = mk(0, 4'b0000, a_lat, 4'b0000, 19'h55, 0, 3, 24'h40, 0);
    tbl[13] = mk(0, 4'b0000, a_lat, 4'b0000, 19'h55, 1, 2, 24'h00AB12, 0);
    tbl[14] = mk(0, 4'b0000, a_lat, 4'b0000, 19'h55, 0, 2, 24'h00AB12, 0);
    // colour key hit and near-miss
    tbl[15] = mk(0, 4'b0011, a_key, 4'b0001, 19'h07, 0, 2, 24'h00AB12, 0);
    tbl[16] = mk(0, 4'b0010, a_key, 4'b0010, 19'h08, 0, 2, 24'h00AB12, 0);
    tbl[17] = mk(0, 4'b0000, a_key, 4'b0000, 19'h08, 1, 0, 24'hFF0000, 1);
    tbl[18] = mk(0, 4'b0000, a_key, 4'b0000, 19'h08, 1, 1, 24'hFF0001, 0);
    tbl[19] = mk(0, 4'b0000, a_key, 4'b0000, 19'h08, 0, 1, 24'hFF0001, 0);
    // lone requester granted every cycle
    tbl[20] = mk(0, 4'b0001, a_rr, 4'b0001, 19'h10, 0, 1, 24'hFF0001, 0);
    tbl[21] = mk(0, 4'b0001, a_rr, 4'b0001, 19'h10, 0, 1, 24'hFF0001, 0);
    tbl[22] = mk(0, 4'b0001, a_rr, 4'b0001, 19'h10, 1, 0, 24'h10, 0);
    tbl[23] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h10, 1, 0, 24'h10, 0);
    tbl[24] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h10, 1, 0, 24'h10, 0);
    tbl[25] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h10, 0, 0, 24'h10, 0);
    // three reads then flush
    tbl[26] = mk(0, 4'b1111, a_rr, 4'b0010, 19'h20, 0, 0, 24'h10, 0);
    tbl[27] = mk(0, 4'b1111, a_rr, 4'b0100, 19'h30, 0, 0, 24'h10, 0);
    tbl[28] = mk(0, 4'b1111, a_rr, 4'b1000, 19'h40, 1, 1, 24'h20, 0);
    tbl[29] = mk(1, 4'b1010, a_rr, 4'b0000, 19'h40, 0, 1, 24'h20, 0);
    tbl[30] = mk(0, 4'b1010, a_rr, 4'b0010, 19'h20, 0, 1, 24'h20, 0);
    tbl[31] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h20, 0, 1, 24'h20, 0);
    tbl[32] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h20, 1, 1, 24'h20, 0);
    tbl[33] = mk(0, 4'b0000, a_rr, 4'b0000, 19'h20, 0, 1, 24'h20, 0);

    Reset_n      = 1'b0;
    bus.flush    = 1'b0;
    bus.req      = 4'b1111;
    bus.req_addr = a_rr;
    #2;
    chk("reset_grant", bus.grant, 4'b0000);
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_rd_valid", bus.rd_valid, 0);
    chk("reset_rd_id", bus.rd_id, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    chk("reset_rd_tr", bus.rd_transparent, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    bus.req = 4'b0000;
    Reset_n = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      @(negedge Clk);
      bus.flush    = tbl[i].flush;
      bus.req      = tbl[i].req;
      bus.req_addr = tbl[i].addrs;
      #1;
      chk($sformatf("row%0d_grant", i), bus.grant, tbl[i].grant);
      @(posedge Clk);
      #1;
      chk($sformatf("row%0d_rom_addr", i), bus.rom_addr, tbl[i].rom_addr);
      chk($sformatf("row%0d_rd_valid", i), bus.rd_valid, tbl[i].rd_valid);
      chk($sformatf("row%0d_rd_id", i), bus.rd_id, tbl[i].rd_id);
      chk($sformatf("row%0d_rd_data", i), bus.rd_data, tbl[i].rd_data);
      chk($sformatf("row%0d_rd_tr", i), bus.rd_transparent, tbl[i].rd_tr);
      $display("row %0d: flush=%0b req=%b grant=%b rom_addr=%0h rd_valid=%0b rd_id=%0d rd_data=%06h tr=%0b",
               i, tbl[i].flush, tbl[i].req, bus.grant, bus.rom_addr, bus.rd_valid, bus.rd_id,
               bus.rd_data, bus.rd_transparent);
    end
    bus.flush = 1'b0;

    // Mid-stream reset with two reads in flight.
    @(negedge Clk);
    bus.req = 4'b1111; bus.req_addr = a_rr;
    #1 chk("midrst_g2", bus.grant, 4'b0100);
    @(posedge Clk);
    @(negedge Clk);
    #1 chk("midrst_g3", bus.grant, 4'b1000);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst_grant", bus.grant, 4'b0000);
    chk("midrst_rom_addr", bus.rom_addr, 0);
    chk("midrst_rd_valid", bus.rd_valid, 0);
    chk("midrst_rd_data", bus.rd_data, 0);
    chk("midrst_rd_id", bus.rd_id, 0);
`ifdef SPRITE_ARB_STATS_EN
    chk("midrst_stall_cnt", stall_cnt, 0);
`endif
    $display("midrst: reset asserted with two reads in flight");
    @(posedge Clk);
    @(negedge Clk);
    bus.req = 4'b0000;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1 chk($sformatf("postrst_rd_valid%0d", i), bus.rd_valid, 0);
    end
    @(negedge Clk);
    bus.req = 4'b1100;
    #1 chk("postrst_grant", bus.grant, 4'b0100);
    @(posedge Clk);
    #1 chk("postrst_rom_addr", bus.rom_addr, 19'h30);
    $display("postrst: first grant=%b rom_addr=%0h", 4'b0100, bus.rom_addr);
    @(negedge Clk);
    bus.req = 4'b0000;

`ifdef SPRITE_ARB_STATS_EN
    bus.flush = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.flush = 1'b0;
    bus.req   = 4'b0011;
    repeat (10) @(posedge Clk);
    #1 chk("stall_cnt_10", stall_cnt, 16'd10);
    $display("stats: stall_cnt=%0d after 10 cycles of req=0011", stall_cnt);
    @(negedge Clk);
    bus.flush = 1'b1;
    @(posedge Clk);
    #1 chk("stall_cnt_flush", stall_cnt, 16'd0);
    $display("stats: stall_cnt=%0d after flush", stall_cnt);
    @(negedge Clk);
    bus.flush = 1'b0;
    bus.req   = 4'b0000;
`endif

    @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
